// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates icache word fetches and LSB loads/stores onto the 8-bit RAM/IO bus.
// Optional macro MEM_CTRL_IO_GUARD_EN holds IO-space bytes while the IO output buffer is full.
module mem_ctrl #(
  parameter int          ADDR_W  = 32,
  parameter logic [31:0] IO_BASE = 32'h00030000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              ic_ena,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_valid,
  output logic [31:0]       ic_data,
  input  logic              lsb_ena,
  input  logic              lsb_wr,
  input  logic [1:0]        lsb_size,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_valid,
  output logic [31:0]       lsb_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic GRANT_IC  = 1'b0;
  localparam logic GRANT_LSB = 1'b1;

  logic [1:0]        state;
  logic              last_grant;
  logic              owner_ic;
  logic [2:0]        cnt;
  logic [2:0]        nbytes;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wbuf;
  logic [31:0]       acc;
  logic [31:0]       acc_next;
  logic [1:0]        byte_idx;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [2:0]        lsb_n;
  logic              ic_req;
  logic              lsb_req;
  logic              grant_lsb;
  logic              grant_ic;
  logic              io_wr_hold_new;
  logic              io_wr_hold;
  logic              ic_io_wait;
  logic              lsb_io_wait;

`ifdef MEM_CTRL_IO_GUARD_EN
  localparam logic [ADDR_W-1:0] IO_LIMIT = ADDR_W'(IO_BASE);

  assign io_wr_hold_new = io_buffer_full && (lsb_addr >= IO_LIMIT);
  assign io_wr_hold     = io_buffer_full && (cur_addr >= IO_LIMIT);
  assign ic_io_wait     = io_buffer_full && (ic_addr >= IO_LIMIT);
  assign lsb_io_wait    = io_buffer_full && !lsb_wr && (lsb_addr >= IO_LIMIT);
`else
  logic unused_io;

  assign unused_io      = io_buffer_full ^ (|IO_BASE);
  assign io_wr_hold_new = 1'b0;
  assign io_wr_hold     = 1'b0;
  assign ic_io_wait     = 1'b0;
  assign lsb_io_wait    = 1'b0;
`endif

  // Holding the registered strobe and gating it here lets a byte stalled by rdy reissue unchanged.
  assign mem_wr   = mem_wr_q & rdy;
  assign cur_addr = base + ADDR_W'(cnt);
  assign byte_idx = 2'(cnt - 3'd2);

  always_comb begin
    case (lsb_size)
      2'd0:    lsb_n = 3'd1;
      2'd1:    lsb_n = 3'd2;
      default: lsb_n = 3'd4;
    endcase
  end

  always_comb begin
    ic_req    = ic_ena && !clr && !ic_io_wait;
    lsb_req   = lsb_ena && !lsb_io_wait;
    grant_lsb = lsb_req && (!ic_req || (last_grant == GRANT_IC));
    grant_ic  = ic_req && !grant_lsb;
  end

  always_comb begin
    acc_next = acc;
    acc_next[{byte_idx, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= GRANT_IC;
      owner_ic   <= 1'b0;
      cnt        <= '0;
      nbytes     <= '0;
      base       <= '0;
      wbuf       <= '0;
      acc        <= '0;
      mem_wr_q   <= 1'b0;
      mem_a      <= '0;
      mem_dout   <= '0;
      ic_valid   <= 1'b0;
      lsb_valid  <= 1'b0;
      ic_data    <= '0;
      lsb_rdata  <= '0;
    end else if (rdy) begin
      ic_valid  <= 1'b0;
      lsb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_lsb) begin
            owner_ic   <= 1'b0;
            last_grant <= GRANT_LSB;
            base       <= lsb_addr;
            nbytes     <= lsb_n;
            wbuf       <= lsb_wdata;
            acc        <= '0;
            mem_a      <= lsb_addr;
            if (lsb_wr) begin
              state <= S_WRITE;
              if (io_wr_hold_new) begin
                mem_wr_q <= 1'b0;
                cnt      <= 3'd0;
              end else begin
                mem_dout <= lsb_wdata[7:0];
                mem_wr_q <= 1'b1;
                cnt      <= 3'd1;
              end
            end else begin
              state <= S_READ;
              cnt   <= 3'd1;
            end
          end else if (grant_ic) begin
            owner_ic   <= 1'b1;
            last_grant <= GRANT_IC;
            base       <= ic_addr;
            nbytes     <= 3'd4;
            acc        <= '0;
            mem_a      <= ic_addr;
            state      <= S_READ;
            cnt        <= 3'd1;
          end
        end

        S_READ: begin
          // A flush only kills instruction fetches; LSB reads always finish.
          if (owner_ic && clr) begin
            state <= S_IDLE;
          end else begin
            if (cnt < nbytes) mem_a <= cur_addr;
            if (cnt >= 3'd2) acc <= acc_next;
            if (cnt == nbytes + 3'd1) begin
              state <= S_DONE;
              if (owner_ic) begin
                ic_valid <= 1'b1;
                ic_data  <= acc_next;
              end else begin
                lsb_valid <= 1'b1;
                lsb_rdata <= acc_next;
              end
            end
            cnt <= cnt + 3'd1;
          end
        end

        S_WRITE: begin
          if (cnt < nbytes) begin
            if (io_wr_hold) begin
              mem_wr_q <= 1'b0;
            end else begin
              mem_a    <= cur_addr;
              mem_dout <= wbuf[{cnt[1:0], 3'b000} +: 8];
              mem_wr_q <= 1'b1;
              cnt      <= cnt + 3'd1;
            end
          end else begin
            mem_wr_q  <= 1'b0;
            lsb_valid <= 1'b1;
            state     <= S_DONE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
